// File: rtl/hazard_unit_mc_if.sv
// hazard_unit_mc_if: bundle of the pipeline-state inputs and hazard control outputs
// exchanged between the datapath and hazard_unit_mc.
//   master : datapath side (drives stage fields, receives controls)
//   slave  : hazard unit side
// Optional macro HAZARD_FWD_D_EN adds the D-stage branch-comparator forwarding selects
// fwd_a_d / fwd_b_d.
interface hazard_unit_mc_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) ();
  // D stage
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              id_is_branch;
  logic              id_is_muldiv;
  logic              id_reads_hilo;
  // E stage
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic              ex_regwrite;
  logic              ex_memtoreg;
  logic [REG_AW-1:0] ex_wreg;
  // M stage
  logic              mem_regwrite;
  logic              mem_memtoreg;
  logic [REG_AW-1:0] mem_wreg;
  // W stage
  logic              wb_regwrite;
  logic [REG_AW-1:0] wb_wreg;
  logic              redirect;
  // Controls
  logic [1:0]        fwd_a_e;
  logic [1:0]        fwd_b_e;
  logic              stall_f;
  logic              stall_d;
  logic              flush_d;
  logic              flush_e;
  logic              muldiv_busy;
  logic [CNT_W-1:0]  stall_cycles;
`ifdef HAZARD_FWD_D_EN
  logic              fwd_a_d;
  logic              fwd_b_d;
`endif

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, id_is_muldiv, id_reads_hilo,
    output ex_rs, ex_rt, ex_regwrite, ex_memtoreg, ex_wreg,
    output mem_regwrite, mem_memtoreg, mem_wreg, wb_regwrite, wb_wreg, redirect,
`ifdef HAZARD_FWD_D_EN
    input  fwd_a_d, fwd_b_d,
`endif
    input  fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e, muldiv_busy, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, id_is_muldiv, id_reads_hilo,
    input  ex_rs, ex_rt, ex_regwrite, ex_memtoreg, ex_wreg,
    input  mem_regwrite, mem_memtoreg, mem_wreg, wb_regwrite, wb_wreg, redirect,
`ifdef HAZARD_FWD_D_EN
    output fwd_a_d, fwd_b_d,
`endif
    output fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e, muldiv_busy, stall_cycles
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: hazard unit for the 5-stage MIPS pipeline.
//   - E-stage operand forwarding (M over W, register 0 never forwarded)
//   - load-use stall, D-stage branch-operand stall, HI/LO stall behind a multicycle MUL/DIV
//   - redirect flushes D and E and suppresses any stall
//   - saturating stalled-cycle counter
// Ports:
//   clk   : pipeline clock, rising edge
//   rst_n : asynchronous active-low reset
//   hz    : hazard_unit_mc_if.slave (stage fields in, stall/flush/forward controls out)
// Optional macro HAZARD_FWD_D_EN: forwards M-stage ALU results to the D branch comparator
// (fwd_a_d / fwd_b_d) so only EX writers and M loads stall a branch.
module hazard_unit_mc #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_unit_mc_if.slave  hz
);

  localparam int unsigned CntW = $clog2(MULDIV_LAT + 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic [1:0] fwd_a, fwd_b;
  logic       hit_ex, hit_mem;
  logic       lu, bh, mh, stall;
  logic       busy;

  // E-stage forwarding
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (hz.mem_regwrite && (hz.mem_wreg == hz.ex_rs) && (hz.ex_rs != '0)) begin
      fwd_a = 2'b10;
    end else if (hz.wb_regwrite && (hz.wb_wreg == hz.ex_rs) && (hz.ex_rs != '0)) begin
      fwd_a = 2'b01;
    end
    if (hz.mem_regwrite && (hz.mem_wreg == hz.ex_rt) && (hz.ex_rt != '0)) begin
      fwd_b = 2'b10;
    end else if (hz.wb_regwrite && (hz.wb_wreg == hz.ex_rt) && (hz.ex_rt != '0)) begin
      fwd_b = 2'b01;
    end
  end

  // D-stage source matches against the E and M destinations
  always_comb begin
    hit_ex  = (hz.ex_wreg != '0) &&
              ((hz.id_uses_rs && (hz.id_rs == hz.ex_wreg)) ||
               (hz.id_uses_rt && (hz.id_rt == hz.ex_wreg)));
    hit_mem = (hz.mem_wreg != '0) &&
              ((hz.id_uses_rs && (hz.id_rs == hz.mem_wreg)) ||
               (hz.id_uses_rt && (hz.id_rt == hz.mem_wreg)));
  end

  assign busy = (state_q == StBusy);
  assign lu   = hz.ex_memtoreg && hz.ex_regwrite && hit_ex;
  assign mh   = (hz.id_is_muldiv || hz.id_reads_hilo) && busy;

`ifdef HAZARD_FWD_D_EN
  // M-stage ALU results reach the comparator, so only M loads still have to wait
  assign bh = hz.id_is_branch &&
              ((hz.ex_regwrite && hit_ex) || (hz.mem_regwrite && hz.mem_memtoreg && hit_mem));
  assign hz.fwd_a_d = hz.mem_regwrite && !hz.mem_memtoreg && (hz.mem_wreg != '0) &&
                      (hz.mem_wreg == hz.id_rs);
  assign hz.fwd_b_d = hz.mem_regwrite && !hz.mem_memtoreg && (hz.mem_wreg != '0) &&
                      (hz.mem_wreg == hz.id_rt);
`else
  assign bh = hz.id_is_branch &&
              ((hz.ex_regwrite && hit_ex) || (hz.mem_regwrite && hit_mem));
  logic unused_mem_memtoreg;
  assign unused_mem_memtoreg = hz.mem_memtoreg;
`endif

  // Redirect wins: the stalled instruction is being discarded anyway
  assign stall = (lu || bh || mh) && !hz.redirect;

  // MUL/DIV scoreboard
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (hz.id_is_muldiv && !stall && !hz.redirect) begin
          state_d = StBusy;
          cnt_d   = CntW'(MULDIV_LAT);
        end
      end
      StBusy: begin
        // An issued operation always completes, redirect or not
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Saturating stall counter
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign hz.fwd_a_e      = fwd_a;
  assign hz.fwd_b_e      = fwd_b;
  assign hz.stall_f      = stall;
  assign hz.stall_d      = stall;
  assign hz.flush_d      = hz.redirect;
  assign hz.flush_e      = stall || hz.redirect;
  assign hz.muldiv_busy  = busy;
  assign hz.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed testbench for hazard_unit_mc. Main instance uses default parameters; a second
// instance with CNT_W=4 exercises counter saturation.
module tb_hazard_unit_mc;
  localparam int unsigned REG_AW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_unit_mc_if #(.REG_AW(REG_AW), .CNT_W(16)) hz ();
  hazard_unit_mc_if #(.REG_AW(REG_AW), .CNT_W(4))  hz4 ();

  hazard_unit_mc #(.REG_AW(REG_AW), .MULDIV_LAT(4), .CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  hazard_unit_mc #(.REG_AW(REG_AW), .MULDIV_LAT(4), .CNT_W(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz4)
  );

  int checks = 0;
  int errors = 0;
  int unsigned exp_cnt = 0;

  // {stall_f, stall_d, flush_d, flush_e}
  logic [3:0] ctl;
  assign ctl = {hz.stall_f, hz.stall_d, hz.flush_d, hz.flush_e};

  localparam logic [3:0] CtlNone  = 4'b0000;
  localparam logic [3:0] CtlStall = 4'b1101;
  localparam logic [3:0] CtlRedir = 4'b0011;

  task automatic clear();
    hz.id_rs = '0; hz.id_rt = '0; hz.id_uses_rs = 0; hz.id_uses_rt = 0;
    hz.id_is_branch = 0; hz.id_is_muldiv = 0; hz.id_reads_hilo = 0;
    hz.ex_rs = '0; hz.ex_rt = '0; hz.ex_regwrite = 0; hz.ex_memtoreg = 0; hz.ex_wreg = '0;
    hz.mem_regwrite = 0; hz.mem_memtoreg = 0; hz.mem_wreg = '0;
    hz.wb_regwrite = 0; hz.wb_wreg = '0; hz.redirect = 0;
  endtask

  task automatic clear4();
    hz4.id_rs = '0; hz4.id_rt = '0; hz4.id_uses_rs = 0; hz4.id_uses_rt = 0;
    hz4.id_is_branch = 0; hz4.id_is_muldiv = 0; hz4.id_reads_hilo = 0;
    hz4.ex_rs = '0; hz4.ex_rt = '0; hz4.ex_regwrite = 0; hz4.ex_memtoreg = 0; hz4.ex_wreg = '0;
    hz4.mem_regwrite = 0; hz4.mem_memtoreg = 0; hz4.mem_wreg = '0;
    hz4.wb_regwrite = 0; hz4.wb_wreg = '0; hz4.redirect = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    clear();
    clear4();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (ctl !== CtlNone) begin
      errors++; $display("FAIL reset_ctl: got %b want %b", ctl, CtlNone);
    end
    checks++;
    if ({hz.fwd_a_e, hz.fwd_b_e} !== 4'b0000) begin
      errors++; $display("FAIL reset_fwd: got %b want 0000", {hz.fwd_a_e, hz.fwd_b_e});
    end
    checks++;
    if (hz.muldiv_busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", hz.muldiv_busy);
    end
    checks++;
    if (hz.stall_cycles !== 16'd0 || hz4.stall_cycles !== 4'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", hz.stall_cycles, hz4.stall_cycles);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  typedef struct {
    logic [4:0] ex_rs, ex_rt;
    logic       mem_rw;
    logic [4:0] mem_wreg;
    logic       wb_rw;
    logic [4:0] wb_wreg;
    logic [1:0] exp_a, exp_b;
  } fwd_vec_t;

  task automatic test_forwarding();
    fwd_vec_t v[5];
    v[0] = '{5'd5, 5'd6,  1'b1, 5'd5, 1'b1, 5'd5,  2'b10, 2'b00};
    v[1] = '{5'd0, 5'd0,  1'b1, 5'd0, 1'b1, 5'd0,  2'b00, 2'b00};
    v[2] = '{5'd5, 5'd6,  1'b1, 5'd6, 1'b1, 5'd5,  2'b01, 2'b10};
    v[3] = '{5'd7, 5'd7,  1'b0, 5'd7, 1'b1, 5'd7,  2'b01, 2'b01};
    v[4] = '{5'd9, 5'd31, 1'b1, 5'd3, 1'b0, 5'd31, 2'b00, 2'b00};
    for (int i = 0; i < 5; i++) begin
      clear();
      hz.ex_rs = v[i].ex_rs; hz.ex_rt = v[i].ex_rt;
      hz.mem_regwrite = v[i].mem_rw; hz.mem_wreg = v[i].mem_wreg;
      hz.wb_regwrite = v[i].wb_rw; hz.wb_wreg = v[i].wb_wreg;
      @(negedge clk);
      checks++;
      if (hz.fwd_a_e !== v[i].exp_a || hz.fwd_b_e !== v[i].exp_b) begin
        errors++;
        $display("FAIL fwd_e[%0d]: got a=%b b=%b want a=%b b=%b", i, hz.fwd_a_e, hz.fwd_b_e,
                 v[i].exp_a, v[i].exp_b);
      end
      step();
    end
  endtask

  task automatic test_load_use();
    // lw $3 in E, add reading $3 in D
    clear();
    hz.ex_memtoreg = 1; hz.ex_regwrite = 1; hz.ex_wreg = 5'd3;
    hz.id_uses_rs = 1; hz.id_rs = 5'd3; hz.id_uses_rt = 1; hz.id_rt = 5'd4;
    @(negedge clk);
    checks++;
    if (ctl !== CtlStall) begin
      errors++; $display("FAIL lu_ctl: got %b want %b", ctl, CtlStall);
    end
    checks++;
    if (hz.stall_cycles !== 16'(exp_cnt)) begin
      errors++; $display("FAIL lu_cnt_before: got %0d want %0d", hz.stall_cycles, exp_cnt);
    end
    step();
    exp_cnt++;
    // Bubble now in E, load moved to M
    hz.ex_memtoreg = 0; hz.ex_regwrite = 0; hz.ex_wreg = '0;
    hz.mem_regwrite = 1; hz.mem_memtoreg = 1; hz.mem_wreg = 5'd3;
    @(negedge clk);
    checks++;
    if (ctl !== CtlNone) begin
      errors++; $display("FAIL lu_release_ctl: got %b want %b", ctl, CtlNone);
    end
    checks++;
    if (hz.stall_cycles !== 16'(exp_cnt)) begin
      errors++; $display("FAIL lu_cnt_after: got %0d want %0d", hz.stall_cycles, exp_cnt);
    end
    step();
    // Match on rt only
    clear();
    hz.ex_memtoreg = 1; hz.ex_regwrite = 1; hz.ex_wreg = 5'd9;
    hz.id_rs = 5'd9; hz.id_uses_rt = 1; hz.id_rt = 5'd9;
    @(negedge clk);
    checks++;
    if (ctl !== CtlStall) begin
      errors++; $display("FAIL lu_rt_ctl: got %b want %b", ctl, CtlStall);
    end
    step();
    exp_cnt++;
    // Load to $0 never stalls
    clear();
    hz.ex_memtoreg = 1; hz.ex_regwrite = 1; hz.ex_wreg = 5'd0;
    hz.id_uses_rs = 1; hz.id_rs = 5'd0;
    @(negedge clk);
    checks++;
    if (ctl !== CtlNone) begin
      errors++; $display("FAIL lu_r0_ctl: got %b want %b", ctl, CtlNone);
    end
    step();
    // Matching register that D does not read
    clear();
    hz.ex_memtoreg = 1; hz.ex_regwrite = 1; hz.ex_wreg = 5'd4;
    hz.id_rs = 5'd4; hz.id_rt = 5'd4;
    @(negedge clk);
    checks++;
    if (ctl !== CtlNone) begin
      errors++; $display("FAIL lu_unused_ctl: got %b want %b", ctl, CtlNone);
    end
    step();
  endtask

  task automatic test_redirect();
    clear();
    hz.ex_memtoreg = 1; hz.ex_regwrite = 1; hz.ex_wreg = 5'd3;
    hz.id_uses_rs = 1; hz.id_rs = 5'd3; hz.redirect = 1;
    @(negedge clk);
    checks++;
    if (ctl !== CtlRedir) begin
      errors++; $display("FAIL redir_lu_ctl: got %b want %b", ctl, CtlRedir);
    end
    step();
    clear();
    @(negedge clk);
    checks++;
    if (hz.stall_cycles !== 16'(exp_cnt)) begin
      errors++; $display("FAIL redir_cnt: got %0d want %0d", hz.stall_cycles, exp_cnt);
    end
    step();
  endtask

  typedef struct {
    logic       ex_rw;
    logic [4:0] ex_wreg;
    logic       mem_rw, mem_mtr;
    logic [4:0] mem_wreg;
    logic       is_branch;
    logic       stall_base, stall_fwd;
    logic       fa, fb;
  } br_vec_t;

  task automatic test_branch();
    br_vec_t v[5];
    logic exp_stall;
    // D: beq $7, $2
    v[0] = '{1'b0, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    v[1] = '{1'b1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    v[2] = '{1'b0, 5'd0, 1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    v[3] = '{1'b0, 5'd0, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    v[4] = '{1'b0, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      clear();
      hz.id_uses_rs = 1; hz.id_rs = 5'd7; hz.id_uses_rt = 1; hz.id_rt = 5'd2;
      hz.id_is_branch = v[i].is_branch;
      hz.ex_regwrite = v[i].ex_rw; hz.ex_wreg = v[i].ex_wreg;
      hz.mem_regwrite = v[i].mem_rw; hz.mem_memtoreg = v[i].mem_mtr; hz.mem_wreg = v[i].mem_wreg;
`ifdef HAZARD_FWD_D_EN
      exp_stall = v[i].stall_fwd;
`else
      exp_stall = v[i].stall_base;
`endif
      @(negedge clk);
      checks++;
      if (ctl !== (exp_stall ? CtlStall : CtlNone)) begin
        errors++;
        $display("FAIL branch_ctl[%0d]: got %b want %b", i, ctl, exp_stall ? CtlStall : CtlNone);
      end
`ifdef HAZARD_FWD_D_EN
      checks++;
      if ({hz.fwd_a_d, hz.fwd_b_d} !== {v[i].fa, v[i].fb}) begin
        errors++;
        $display("FAIL branch_fwd_d[%0d]: got %b%b want %b%b", i, hz.fwd_a_d, hz.fwd_b_d,
                 v[i].fa, v[i].fb);
      end
`endif
      step();
      if (exp_stall) exp_cnt++;
    end
  endtask

  task automatic test_muldiv();
    clear();
    hz.id_is_muldiv = 1;
    @(negedge clk);
    checks++;
    if (ctl !== CtlNone || hz.muldiv_busy !== 1'b0) begin
      errors++; $display("FAIL md_issue: got ctl=%b busy=%b want 0000/0", ctl, hz.muldiv_busy);
    end
    step();
    hz.id_is_muldiv = 0; hz.id_reads_hilo = 1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (ctl !== CtlStall || hz.muldiv_busy !== 1'b1) begin
        errors++;
        $display("FAIL md_mfhi_c%0d: got ctl=%b busy=%b want %b/1", c, ctl, hz.muldiv_busy,
                 CtlStall);
      end
      step();
      exp_cnt++;
    end
    @(negedge clk);
    checks++;
    if (ctl !== CtlNone || hz.muldiv_busy !== 1'b0) begin
      errors++; $display("FAIL md_mfhi_c5: got ctl=%b busy=%b want 0000/0", ctl, hz.muldiv_busy);
    end
    step();
    clear();
    @(negedge clk);
    checks++;
    if (hz.stall_cycles !== 16'(exp_cnt)) begin
      errors++; $display("FAIL md_cnt: got %0d want %0d", hz.stall_cycles, exp_cnt);
    end
    step();
  endtask

  task automatic test_back_to_back();
    // {muldiv, redirect, exp_busy}, exp_ctl
    logic [2:0] v[12];
    logic [3:0] e[12];
    v[0]  = 3'b110; e[0]  = CtlRedir;  // not issued under redirect
    v[1]  = 3'b100; e[1]  = CtlNone;   // issued
    v[2]  = 3'b111; e[2]  = CtlRedir;  // redirect while busy
    v[3]  = 3'b101; e[3]  = CtlStall;
    v[4]  = 3'b101; e[4]  = CtlStall;
    v[5]  = 3'b101; e[5]  = CtlStall;
    v[6]  = 3'b100; e[6]  = CtlNone;   // drained, issued again
    v[7]  = 3'b001; e[7]  = CtlNone;
    v[8]  = 3'b001; e[8]  = CtlNone;
    v[9]  = 3'b001; e[9]  = CtlNone;
    v[10] = 3'b001; e[10] = CtlNone;
    v[11] = 3'b000; e[11] = CtlNone;
    for (int i = 0; i < 12; i++) begin
      logic [2:0] cur;
      cur = v[i];
      clear();
      hz.id_is_muldiv = cur[2]; hz.redirect = cur[1];
      @(negedge clk);
      checks++;
      if (ctl !== e[i] || hz.muldiv_busy !== cur[0]) begin
        errors++;
        $display("FAIL b2b_c%0d: got ctl=%b busy=%b want %b/%b", i, ctl, hz.muldiv_busy, e[i],
                 cur[0]);
      end
      step();
      if (e[i] == CtlStall) exp_cnt++;
    end
    clear();
    @(negedge clk);
    checks++;
    if (hz.stall_cycles !== 16'(exp_cnt)) begin
      errors++; $display("FAIL b2b_cnt: got %0d want %0d", hz.stall_cycles, exp_cnt);
    end
    step();
  endtask

  task automatic test_saturation();
    clear4();
    hz4.ex_memtoreg = 1; hz4.ex_regwrite = 1; hz4.ex_wreg = 5'd8;
    hz4.id_uses_rs = 1; hz4.id_rs = 5'd8;
    for (int c = 0; c < 3; c++) step();
    checks++;
    if (hz4.stall_cycles !== 4'd3) begin
      errors++; $display("FAIL sat_cnt3: got %0d want 3", hz4.stall_cycles);
    end
    for (int c = 3; c < 20; c++) step();
    checks++;
    if (hz4.stall_cycles !== 4'd15) begin
      errors++; $display("FAIL sat_cnt20: got %0d want 15", hz4.stall_cycles);
    end
    clear4();
  endtask

  task automatic test_reset_mid_busy();
    clear();
    hz.id_is_muldiv = 1;
    step();
    clear();
    @(negedge clk);
    checks++;
    if (hz.muldiv_busy !== 1'b1) begin
      errors++; $display("FAIL rst_pre_busy: got %b want 1", hz.muldiv_busy);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    checks++;
    if (hz.muldiv_busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_busy: got %b want 0", hz.muldiv_busy);
    end
    checks++;
    if (hz.stall_cycles !== 16'd0 || hz4.stall_cycles !== 4'd0) begin
      errors++; $display("FAIL rst_mid_cnt: got %0d/%0d want 0/0", hz.stall_cycles,
                         hz4.stall_cycles);
    end
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (hz.muldiv_busy !== 1'b0 || ctl !== CtlNone) begin
      errors++; $display("FAIL rst_after: got busy=%b ctl=%b want 0/0000", hz.muldiv_busy, ctl);
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_redirect();
    test_branch();
    test_muldiv();
    test_back_to_back();
    test_saturation();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
